// File: rtl/slot_allocator_pkg.sv
// Shared helpers for the slot allocator: pointer arithmetic that is
// independent of the pool size an instance is built with.
package slot_allocator_pkg;

  function automatic int wrap_inc(input int idx, input int len);
    return (idx + 1 >= len) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Circular first-set search: picks the first set bit of i_mask scanning
// upward from i_ptr and wrapping, returned as a one-hot vector.
module rr_priority_pick #(
  parameter int LEN   = 32,
  parameter int PTR_W = $clog2(LEN)
) (
  input  logic [LEN-1:0]   i_mask,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [LEN-1:0]   o_pick_oh,
  output logic             o_found
);

  logic [LEN-1:0] w_rot;
  logic [LEN-1:0] w_rot_oh;

  // Rotate so the pointer slot sits at bit 0, isolate the lowest set bit,
  // then rotate the one-hot result back into slot order.
  assign w_rot     = LEN'({i_mask, i_mask} >> i_ptr);
  assign w_rot_oh  = w_rot & (~w_rot + LEN'(1));
  assign o_pick_oh = LEN'(({w_rot_oh, w_rot_oh} << i_ptr) >> LEN);
  assign o_found   = |i_mask;

endmodule

// File: rtl/slot_allocator.sv
// Round-robin slot pool: grants one free slot per request cycle with a
// registered one-hot grant, and tracks busy slots, fullness and free count.
module slot_allocator
  import slot_allocator_pkg::*;
#(
  parameter int LEN   = 32,
  parameter int IDX_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_req,
  input  logic [LEN-1:0]   IN_free,
  input  logic             IN_flush,
  output logic [LEN-1:0]   OUT_allocOH,
  output logic             OUT_valid,
  output logic             OUT_full,
  output logic [IDX_W-1:0] OUT_freeCount
);

  localparam int PTR_W = $clog2(LEN);

  logic [LEN-1:0]   r_busy;
  logic [PTR_W-1:0] r_ptr;
  logic [LEN-1:0]   r_alloc_oh;
  logic             r_valid;
  logic             r_full;
  logic [IDX_W-1:0] r_free_cnt;

  logic [LEN-1:0]   w_pick_oh;
  logic             w_found;
  logic             w_grant;
  logic [PTR_W-1:0] w_pick_idx;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [LEN-1:0]   w_busy_nxt;

  function automatic logic [IDX_W-1:0] count_free(input logic [LEN-1:0] busy);
    logic [IDX_W-1:0] n;
    n = '0;
    for (int i = 0; i < LEN; i++) begin
      if (!busy[i]) n = n + IDX_W'(1);
    end
    return n;
  endfunction

  // Candidates come from the registered busy vector, so slots being
  // released this cycle are still excluded from the search.
  rr_priority_pick #(
    .LEN   (LEN),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_mask    (~r_busy),
    .i_ptr     (r_ptr),
    .o_pick_oh (w_pick_oh),
    .o_found   (w_found)
  );

  assign w_grant = IN_req & w_found & ~IN_flush;

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < LEN; i++) begin
      if (w_pick_oh[i]) w_pick_idx = PTR_W'(i);
    end
  end

  assign w_ptr_nxt  = PTR_W'(wrap_inc(32'(w_pick_idx), LEN));
  assign w_busy_nxt = IN_flush ? '0
                    : ((r_busy & ~IN_free) | (w_grant ? w_pick_oh : '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_ptr      <= '0;
      r_alloc_oh <= '0;
      r_valid    <= 1'b0;
      r_full     <= 1'b0;
      r_free_cnt <= IDX_W'(LEN);
    end else begin
      r_busy     <= w_busy_nxt;
      if (IN_flush)     r_ptr <= '0;
      else if (w_grant) r_ptr <= w_ptr_nxt;
      r_alloc_oh <= w_grant ? w_pick_oh : '0;
      r_valid    <= w_grant;
      r_full     <= &w_busy_nxt;
      r_free_cnt <= count_free(w_busy_nxt);
    end
  end

  assign OUT_allocOH   = r_alloc_oh;
  assign OUT_valid     = r_valid;
  assign OUT_full      = r_full;
  assign OUT_freeCount = r_free_cnt;

  a_free_only_busy: assert property (@(posedge clk) disable iff (rst)
    !IN_flush |-> ((IN_free & ~r_busy) == '0));

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(r_alloc_oh) && (r_valid == (|r_alloc_oh)));

endmodule

// File: tb/tb_slot_allocator.sv
// Randomised and directed scoreboard bench for slot_allocator with a
// four-slot pool and an array-based behavioural pool model.
module tb_slot_allocator;

  localparam int LEN   = 4;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst;
  logic             IN_req;
  logic [LEN-1:0]   IN_free;
  logic             IN_flush;
  logic [LEN-1:0]   OUT_allocOH;
  logic             OUT_valid;
  logic             OUT_full;
  logic [IDX_W-1:0] OUT_freeCount;

  slot_allocator #(.LEN(LEN), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .IN_req        (IN_req),
    .IN_free       (IN_free),
    .IN_flush      (IN_flush),
    .OUT_allocOH   (OUT_allocOH),
    .OUT_valid     (OUT_valid),
    .OUT_full      (OUT_full),
    .OUT_freeCount (OUT_freeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LEN-1:0] alloc;
    logic           valid;
    logic           full;
    int             free_cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int m_busy[LEN];
  int m_ptr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LEN; i++) m_busy[i] = 0;
    m_ptr = 0;
  endtask

  function automatic logic [LEN-1:0] model_busy_mask();
    logic [LEN-1:0] m;
    m = '0;
    for (int i = 0; i < LEN; i++) if (m_busy[i] != 0) m[i] = 1'b1;
    return m;
  endfunction

  // Behavioural pool: search on current occupancy, then apply frees and grant.
  task automatic model_step(input logic req, input logic [LEN-1:0] fr, input logic fl);
    exp_t e;
    int   slot;
    int   nfree;
    e.alloc = '0;
    e.valid = 1'b0;
    slot    = -1;
    if (fl) begin
      model_reset();
    end else begin
      if (req) begin
        for (int k = 0; k < LEN; k++) begin
          if (slot < 0 && m_busy[(m_ptr + k) % LEN] == 0) slot = (m_ptr + k) % LEN;
        end
      end
      for (int i = 0; i < LEN; i++) if (fr[i]) m_busy[i] = 0;
      if (slot >= 0) begin
        m_busy[slot] = 1;
        m_ptr        = (slot + 1) % LEN;
        e.alloc      = LEN'(1) << slot;
        e.valid      = 1'b1;
      end
    end
    nfree = 0;
    for (int i = 0; i < LEN; i++) if (m_busy[i] == 0) nfree++;
    e.free_cnt = nfree;
    e.full     = (nfree == 0);
    q.push_back(e);
  endtask

  // Drive one cycle of inputs (called at posedge+2), then advance so the
  // outputs for those inputs are visible on return.
  task automatic step(input logic req, input logic [LEN-1:0] fr, input logic fl);
    IN_req   = req;
    IN_free  = fr;
    IN_flush = fl;
    model_step(req, fr, fl);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() != 0) begin
        e = q.pop_front();
        chk("sb_alloc", int'(OUT_allocOH), int'(e.alloc));
        chk("sb_valid", int'(OUT_valid), int'(e.valid));
        chk("sb_full", int'(OUT_full), int'(e.full));
        chk("sb_freecnt", int'(OUT_freeCount), e.free_cnt);
      end
    end
  end

  initial begin : stim
    logic [LEN-1:0] exp_seq [4];
    logic [LEN-1:0] fr;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;

    rst = 1'b1; IN_req = 1'b0; IN_free = '0; IN_flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", int'(OUT_valid), 0);
    chk("rst_alloc", int'(OUT_allocOH), 0);
    chk("rst_full", int'(OUT_full), 0);
    chk("rst_freecnt", int'(OUT_freeCount), LEN);
    rst = 1'b0;

    // Consecutive grants from an empty pool
    for (int i = 0; i < 4; i++) begin
      step(1'b1, '0, 1'b0);
      chk("seq_alloc", int'(OUT_allocOH), int'(exp_seq[i]));
      chk("seq_freecnt", int'(OUT_freeCount), 3 - i);
    end
    chk("seq_full", int'(OUT_full), 1);

    // Freed slot is not grantable in the freeing cycle
    step(1'b1, 4'b0100, 1'b0);
    chk("free_same_valid", int'(OUT_valid), 0);
    chk("free_same_cnt", int'(OUT_freeCount), 1);
    step(1'b1, '0, 1'b0);
    chk("free_next_alloc", int'(OUT_allocOH), 4'b0100);

    // busy=1011 with ptr=3: scan wraps to slot 2, ptr lands on 3
    step(1'b0, 4'b0100, 1'b0);
    step(1'b1, '0, 1'b0);
    chk("wrap_alloc", int'(OUT_allocOH), 4'b0100);
    step(1'b0, 4'b1001, 1'b0);
    step(1'b1, '0, 1'b0);
    chk("wrap_ptr3", int'(OUT_allocOH), 4'b1000);
    step(1'b1, '0, 1'b0);
    chk("wrap_ptr0", int'(OUT_allocOH), 4'b0001);
    chk("wrap_full", int'(OUT_full), 1);

    // Flush overrides request and frees
    step(1'b1, 4'b0001, 1'b1);
    chk("flush_valid", int'(OUT_valid), 0);
    chk("flush_cnt", int'(OUT_freeCount), 4);
    chk("flush_full", int'(OUT_full), 0);
    step(1'b1, '0, 1'b0);
    chk("flush_next", int'(OUT_allocOH), 4'b0001);

    // Asynchronous reset mid-cycle with busy=0011
    step(1'b1, '0, 1'b0);
    chk("pre_rst_alloc", int'(OUT_allocOH), 4'b0010);
    IN_req = 1'b1; IN_free = '0; IN_flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", int'(OUT_valid), 0);
    chk("arst_alloc", int'(OUT_allocOH), 0);
    chk("arst_cnt", int'(OUT_freeCount), 4);
    chk("arst_full", int'(OUT_full), 0);
    q.delete();
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    step(1'b1, '0, 1'b0);
    chk("post_rst_alloc", int'(OUT_allocOH), 4'b0001);

    // Randomised traffic; frees only ever target busy slots
    for (int n = 0; n < 10000; n++) begin
      fr = '0;
      if ($urandom_range(2) == 0) fr = LEN'($urandom) & model_busy_mask();
      step($urandom_range(3) != 0, fr, $urandom_range(199) == 0);
    end
    step(1'b0, '0, 1'b0);

    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slot_allocator.md
SLOT_ALLOCATOR -- requirements
Module: slot_allocator

Interface
REQ-001 The block SHALL have parameter LEN, default 32, giving the number of pool slots (LEN >= 2).
REQ-002 The block SHALL have parameter IDX_W, default $clog2(LEN+1), giving the width of the free-count output.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 IN_req  input  1  requests one slot this cycle.
REQ-006 IN_free  input  LEN  mask of slots to release; any number of bits may be set.
REQ-007 IN_flush  input  1  releases all slots and restarts the search pointer.
REQ-008 OUT_allocOH  output  LEN  registered one-hot grant; all-zero when no grant.
REQ-009 OUT_valid  output  1  registered; high when OUT_allocOH holds a grant.
REQ-010 OUT_full  output  1  registered; high when every slot is busy.
REQ-011 OUT_freeCount  output  IDX_W  registered count of non-busy slots.

Function
REQ-012 The block SHALL keep a LEN-bit busy vector and a round-robin pointer ptr in 0..LEN-1.
REQ-013 Selection SHALL pick the first non-busy slot scanning ptr, ptr+1, ..., wrapping LEN-1 -> 0, using busy as registered at the start of the cycle.
REQ-014 If IN_req=1, IN_flush=0 and a free slot exists: at the next edge, OUT_allocOH = that slot one-hot, OUT_valid=1, busy[slot]=1, ptr=(slot+1) mod LEN.
REQ-015 Latency SHALL be exactly one cycle from IN_req to OUT_valid; sustained IN_req SHALL yield one grant per cycle while slots remain.
REQ-016 If IN_req=0 or no slot is free, the next-cycle OUT_valid SHALL be 0 and OUT_allocOH all-zero; ptr SHALL be unchanged.
REQ-017 Slots set in IN_free SHALL clear at the next edge but SHALL NOT be selectable in the same cycle they are freed.
REQ-018 Freeing a slot that is not busy SHALL trigger an assertion; busy state stays 0.
REQ-019 IN_flush=1 SHALL take priority: next edge busy=0, ptr=0, OUT_valid=0, OUT_allocOH=0, regardless of IN_req/IN_free.
REQ-020 OUT_allocOH SHALL never have more than one bit set (assertion), and OUT_valid SHALL equal its OR-reduction.
REQ-021 OUT_full and OUT_freeCount SHALL reflect the busy vector after the same edge (including that edge's grant and frees); OUT_freeCount ranges 0..LEN.
REQ-022 There SHALL be no combinational path from any input to any output.

Reset
REQ-023 On rst: busy=0, ptr=0, OUT_allocOH=0, OUT_valid=0, OUT_full=0, OUT_freeCount=LEN.
REQ-024 Reset asserted mid-operation SHALL discard all grants and busy state immediately (asynchronously); the first grant after deassertion SHALL be slot 0.

Structure
REQ-025 No shared-package typedefs are required; LEN and IDX_W SHALL remain module parameters so the instance can feed any pool size.
REQ-026 Circular first-free search SHALL be a separate combinational sub-module, rr_priority_pick (inputs: LEN-bit candidate mask, pointer; outputs: one-hot pick, found flag).
REQ-027 Busy vector, ptr, and output registers SHALL live in slot_allocator; the population count for OUT_freeCount SHALL be computed from next-state busy.

Verification (LEN=4)
REQ-028 After reset, IN_req=1 for 4 cycles -> OUT_allocOH 0001, 0010, 0100, 1000 on consecutive cycles; OUT_full=1 after the fourth; OUT_freeCount 3,2,1,0.
REQ-029 Pool full, IN_req=1 with IN_free=0100 in same cycle -> next cycle OUT_valid=0; following cycle with IN_req=1 -> OUT_allocOH=0100.
REQ-030 Busy=1011, ptr=3, IN_req=1 -> scan wraps; OUT_allocOH=0100, ptr becomes 3 (slot 2 + 1).
REQ-031 Busy=1111, IN_flush=1 with IN_req=1 and IN_free=0001 -> next cycle OUT_valid=0, OUT_freeCount=4, OUT_full=0; next IN_req grants 0001.
REQ-032 Assert rst asynchronously between edges while IN_req=1 and busy=0011 -> outputs zero immediately, OUT_freeCount=4; first post-reset grant 0001.
REQ-033 Randomised IN_req/IN_free (busy slots only) for 10k cycles -> OUT_allocOH always one-hot-or-zero, never grants a busy slot, OUT_freeCount matches scoreboard.
